pio_key_in: RTL and testbench

//  Avalon-MM slave input PIO: samples an external key/switch bus, detects edges, and raises an IRQ.
//  It is the input-direction counterpart of the LED output PIO in the Qsys system.

---
 rtl/pio_pkg.sv | 19 +
 rtl/pio_in_debounce.sv | 34 +++
 rtl/pio_key_in.sv | 113 +++++++++++
 tb/tb_pio_key_in.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// Shared register map and encodings for the key/switch input PIO.
package pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  typedef enum logic {
    IRQ_EDGE  = 1'b0,
    IRQ_LEVEL = 1'b1
  } irq_type_e;

endpackage

// File: rtl/pio_in_debounce.sv
// One-bit debouncer: a bit is accepted only after it holds a new value for DEBOUNCE_CYCLES cycles.
module pio_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic          stable_reg;

  // Any return to the accepted value restarts the count, so short glitches never land.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (din == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg    <= '0;
      stable_reg <= din;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign dout = stable_reg;

endmodule

// File: rtl/pio_key_in.sv
// Avalon-MM input PIO with edge capture and IRQ; optional per-bit debounce under PIO_IN_DEBOUNCE_EN.
module pio_key_in
  import pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int IRQ_TYPE        = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] irqmask_reg;
  logic [WIDTH-1:0] edgecap_reg;
  logic [WIDTH-1:0] edgecap_next;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edges;
  logic             wr_strobe;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
      pio_in_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .reset_n(reset_n),
        .din    (sync2_reg[gi]),
        .dout   (d[gi])
      );
    end
  endgenerate
`else
  assign d = sync2_reg;
`endif

  assign rise = d & ~prev_reg;
  assign fall = ~d & prev_reg;

  always_comb begin
    edges = rise;
    case (EDGE_TYPE)
      int'(EDGE_FALL): edges = fall;
      int'(EDGE_ANY):  edges = rise | fall;
      default:         edges = rise;
    endcase
  end

  assign wr_strobe = chipselect & ~write_n;

  // Clear first, then OR in new edges so a coincident edge wins over the clear.
  always_comb begin
    edgecap_next = edgecap_reg;
    if (wr_strobe && address == ADDR_EDGECAP)
      edgecap_next = edgecap_next & ~writedata[WIDTH-1:0];
    edgecap_next = edgecap_next | edges;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg    <= '0;
      irqmask_reg <= '0;
      edgecap_reg <= '0;
    end else begin
      prev_reg    <= d;
      edgecap_reg <= edgecap_next;
      if (wr_strobe && address == ADDR_IRQMASK)
        irqmask_reg <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:    readdata = 32'(d);
      ADDR_IRQMASK: readdata = 32'(irqmask_reg);
      ADDR_EDGECAP: readdata = 32'(edgecap_reg);
      default:      readdata = 32'd0;
    endcase
  end

  generate
    if (IRQ_TYPE == int'(IRQ_LEVEL)) begin : g_irq_level
      assign irq = |(d & irqmask_reg);
    end else begin : g_irq_edge
      assign irq = |(edgecap_reg & irqmask_reg);
    end
  endgenerate

endmodule

// File: tb/tb_pio_key_in.sv
// Directed bench for pio_key_in (WIDTH=4, falling-edge capture, edge IRQ); debounce case under PIO_IN_DEBOUNCE_EN.
module tb_pio_key_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  pio_key_in #(
    .WIDTH(4), .EDGE_TYPE(1), .IRQ_TYPE(0), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = readdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    address    = a;
    writedata  = v;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  logic [31:0] v;
  logic [31:0] acc;

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 4'hF;
    tick(3);
    rd(3'd0, v); check("reset_data", v, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);

`ifndef PIO_IN_DEBOUNCE_EN
    // 1: reset release with inputs high
    reset_n = 1'b1;
    tick(3);
    rd(3'd0, v); check("t1_data_F", v, 32'hF);
    rd(3'd3, v); check("t1_edgecap0", v, 32'h0);
    rd(3'd2, v); check("t1_irqmask0", v, 32'h0);
    check("t1_irq0", {31'd0, irq}, 32'h0);

    // 2: masked falling edge on bit0 raises irq, W1C clears it
    wr(3'd2, 32'h5);
    rd(3'd2, v); check("t2_irqmask5", v, 32'h5);
    in_port = 4'hE;
    tick(2);
    rd(3'd0, v); check("t2_data_E", v, 32'hE);
    rd(3'd3, v); check("t2_edgecap_N1", v, 32'h0);
    tick();
    rd(3'd3, v); check("t2_edgecap_N2", v, 32'h1);
    check("t2_irq1", {31'd0, irq}, 32'h1);
    wr(3'd3, 32'h1);
    rd(3'd3, v); check("t2_edgecap_clr", v, 32'h0);
    check("t2_irq_clr", {31'd0, irq}, 32'h0);

    // 3: unmasked-bit edge captured but no irq; bit0 rise ignored
    in_port = 4'hD;
    tick(3);
    rd(3'd3, v); check("t3_edgecap2", v, 32'h2);
    check("t3_irq0", {31'd0, irq}, 32'h0);
    rd(3'd1, v); check("t3_addr1_zero", v, 32'h0);
    wr(3'd0, 32'hF);
    wr(3'd3, 32'h2);
    rd(3'd0, v); check("t3_data_ro", v, 32'hD);
    rd(3'd3, v); check("t3_edgecap_clr", v, 32'h0);

    // 4: clear coinciding with a new edge on the same bit: set wins
    in_port = 4'hC;
    tick(3);
    rd(3'd3, v); check("t4_edgecap1", v, 32'h1);
    in_port = 4'hD;
    tick(3);
    rd(3'd3, v); check("t4_sticky", v, 32'h1);
    in_port = 4'hC;
    tick(2);
    wr(3'd3, 32'h1);
    rd(3'd3, v); check("t4_set_wins", v, 32'h1);

    // 5: async reset mid-operation clears everything at once
    in_port = 4'hE;
    tick(3);
    in_port = 4'hC;
    tick(3);
    rd(3'd3, v); check("t5_edgecap3", v, 32'h3);
    check("t5_irq1", {31'd0, irq}, 32'h1);
    reset_n = 1'b0;
    #1;
    rd(3'd3, v); check("t5_rst_edgecap", v, 32'h0);
    rd(3'd2, v); check("t5_rst_irqmask", v, 32'h0);
    check("t5_rst_irq", {31'd0, irq}, 32'h0);
`else
    // 6: debounce with DEBOUNCE_CYCLES=8
    reset_n = 1'b1;
    tick(14);
    rd(3'd0, v); check("t6_data_F", v, 32'hF);
    rd(3'd3, v); check("t6_edgecap0", v, 32'h0);
    in_port = 4'hE;
    tick(5);
    in_port = 4'hF;
    acc = 32'hF;
    for (int i = 0; i < 20; i++) begin
      rd(3'd0, v);
      acc = acc & v;
      tick();
    end
    check("t6_glitch_data", acc, 32'hF);
    rd(3'd3, v); check("t6_glitch_edgecap", v, 32'h0);
    in_port = 4'hE;
    tick(10);
    rd(3'd0, v); check("t6_data_E", v, 32'hE);
    rd(3'd3, v); check("t6_edgecap_early", v, 32'h0);
    tick();
    rd(3'd3, v); check("t6_edgecap1", v, 32'h1);
    check("t6_irq_masked", {31'd0, irq}, 32'h0);
    tick(2);
    in_port = 4'hF;
    tick(12);
    rd(3'd3, v); check("t6_sticky", v, 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
